// File: rtl/seq_detector_prog.sv
// seq_detector_prog
//   Programmable serial pattern detector. One bit of `in` is taken per cycle
//   with en=1. The most recent cfg_len bits are compared against a pattern
//   that is loaded at runtime. After reset the block detects 10110 with
//   overlapping matches.
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   en, in            sample enable and serial data bit
//   cfg_load          load cfg_pattern/cfg_len/cfg_overlap this cycle
//   cfg_pattern       pattern; bit [cfg_len-1] is received first, bit [0] last
//   cfg_len           pattern length, legal range 1..MAX_LEN
//   cfg_overlap       1 = matched bits may be reused by the next match
//   count_clr         synchronous clear of match_count; wins over a match
//   op                registered match pulse, high for one cycle
//   match_count       saturating match counter
//   cfg_err           one-cycle pulse when a load carried an illegal length
module seq_detector_prog #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               in,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               count_clr,
  output logic               op,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_err
);

  typedef struct packed {
    logic [MAX_LEN-1:0] pattern;
    logic [LEN_W-1:0]   len;
    logic               overlap;
  } cfg_t;

  localparam cfg_t CFG_RST = '{pattern: MAX_LEN'(5'b10110),
                               len:     LEN_W'(5),
                               overlap: 1'b1};
  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  cfg_t               cfg_q, cfg_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic               op_q, op_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;

  logic [MAX_LEN-1:0] hist_nxt;
  logic [LEN_W-1:0]   fill_nxt;
  logic [MAX_LEN-1:0] len_mask;
  logic               len_ok;
  logic               hit;

  always_comb begin
    hist_nxt = {hist_q[MAX_LEN-2:0], in};
    fill_nxt = (fill_q >= FILL_MAX) ? fill_q : fill_q + 1'b1;

    // Only the low len bits take part in the compare. Stale history and
    // pattern bits above len are masked off.
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) len_mask[i] = (i < int'(cfg_q.len));

    hit    = (fill_nxt >= cfg_q.len) &&
             (((hist_nxt ^ cfg_q.pattern) & len_mask) == '0);
    len_ok = (cfg_len != '0) && (cfg_len <= FILL_MAX);

    cfg_d  = cfg_q;
    hist_d = hist_q;
    fill_d = fill_q;
    op_d   = 1'b0;
    err_d  = 1'b0;
    cnt_d  = cnt_q;

    if (cfg_load) begin
      // `in` is dropped on a load cycle, whether or not the load is accepted.
      if (len_ok) begin
        cfg_d  = '{pattern: cfg_pattern, len: cfg_len, overlap: cfg_overlap};
        hist_d = '0;
        fill_d = '0;
      end else begin
        err_d = 1'b1;
      end
    end else if (en) begin
      hist_d = hist_nxt;
      // In non-overlap mode, restarting the fill count stops the bits of
      // this match from counting toward the next one.
      fill_d = (hit && !cfg_q.overlap) ? '0 : fill_nxt;
      op_d   = hit;
      if (hit && cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
    end

    if (count_clr) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_q  <= CFG_RST;
      hist_q <= '0;
      fill_q <= '0;
      op_q   <= 1'b0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      cfg_q  <= cfg_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      op_q   <= op_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign op          = op_q;
  assign match_count = cnt_q;
  assign cfg_err     = err_q;

endmodule

// File: tb/tb_seq_detector_prog.sv
module tb_seq_detector_prog;
  localparam int MAX_LEN = 8;

  logic clk, rst, en, in, cfg_load, cfg_overlap, count_clr;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       op, cfg_err, op2, cfg_err2;
  logic [7:0] match_count;
  logic [1:0] match_count2;

  int checks = 0;
  int failures = 0;

  seq_detector_prog #(.MAX_LEN(8), .LEN_W(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .in(in), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .count_clr(count_clr), .op(op), .match_count(match_count), .cfg_err(cfg_err));

  seq_detector_prog #(.MAX_LEN(8), .LEN_W(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .in(in), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .count_clr(count_clr), .op(op2), .match_count(match_count2), .cfg_err(cfg_err2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the bits seen since the last clear, oldest first.
  bit         q[$];
  logic [7:0] m_pat;
  int         m_len;
  bit         m_ovl;
  bit         e_op, e_err;
  int         e_cnt, e_cnt2;

  task automatic model_reset();
    q.delete();
    m_pat = 8'b0001_0110; m_len = 5; m_ovl = 1'b1;
    e_op = 0; e_err = 0; e_cnt = 0; e_cnt2 = 0;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, "_op"},   int'(op),           int'(e_op));
    chk({tag, "_err"},  int'(cfg_err),      int'(e_err));
    chk({tag, "_cnt"},  int'(match_count),  e_cnt);
    chk({tag, "_op2"},  int'(op2),          int'(e_op));
    chk({tag, "_err2"}, int'(cfg_err2),     int'(e_err));
    chk({tag, "_cnt2"}, int'(match_count2), e_cnt2);
  endtask

  // Drive one cycle, advance the model across that edge, then check #1 later.
  task automatic step(input bit ld, input bit e, input bit b, input bit clr,
                      input logic [7:0] pat, input int len, input bit ovl,
                      input string tag);
    bit hitm;
    cfg_load = ld; en = e; in = b; count_clr = clr;
    cfg_pattern = ld ? pat : 8'($urandom);
    cfg_len     = ld ? 4'(len) : 4'($urandom);
    cfg_overlap = ld ? ovl : 1'($urandom);
    @(posedge clk);
    hitm = 0; e_op = 0; e_err = 0;
    if (ld) begin
      if (len >= 1 && len <= MAX_LEN) begin
        m_pat = pat; m_len = len; m_ovl = ovl; q.delete();
      end else e_err = 1;
    end else if (e) begin
      q.push_back(b);
      if (q.size() > MAX_LEN) void'(q.pop_front());
      if (q.size() >= m_len) begin
        hitm = 1;
        for (int k = 0; k < m_len; k++)
          if (q[q.size()-1-k] != m_pat[k]) hitm = 0;
      end
      if (hitm) begin
        e_op = 1;
        if (!m_ovl) q.delete();
      end
    end
    if (clr) begin
      e_cnt = 0; e_cnt2 = 0;
    end else if (hitm) begin
      if (e_cnt < 255) e_cnt++;
      if (e_cnt2 < 3) e_cnt2++;
    end
    #1;
    chk_all(tag);
  endtask

  task automatic feed(input bit b, input string tag);
    step(0, 1, b, 0, 8'h00, 0, 0, tag);
  endtask

  task automatic feed_vec(input logic [15:0] v, input int n, input string tag);
    for (int i = n - 1; i >= 0; i--) feed(v[i], tag);
  endtask

  task automatic load(input logic [7:0] pat, input int len, input bit ovl,
                      input string tag);
    step(1, 0, 1'($urandom), 0, pat, len, ovl, tag);
  endtask

  task automatic clear_cnt();
    step(0, 0, 1'($urandom), 1, 8'h00, 0, 0, "clr");
  endtask

  initial begin
    rst = 1'b1; en = 0; in = 0; cfg_load = 0; count_clr = 0;
    cfg_pattern = '0; cfg_len = '0; cfg_overlap = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // Default 10110 detector: only the final 5 bits form the pattern.
    feed_vec(16'b0101_0111_0111_0110, 16, "dflt");
    chk("dflt_total", int'(match_count), 1);

    // 101 with overlap, then without.
    load(8'b101, 3, 1, "ld101");
    clear_cnt();
    feed_vec(16'b10101, 5, "ovl1");
    chk("ovl1_total", int'(match_count), 2);
    load(8'b101, 3, 0, "ld101n");
    clear_cnt();
    feed_vec(16'b10101, 5, "ovl0");
    chk("ovl0_total", int'(match_count), 1);

    // Rejected loads keep the previous config; restore 10110 first.
    load(8'b10110, 5, 1, "ld10110");
    load(8'hFF, 0, 0, "bad0");
    chk("bad0_err", int'(cfg_err), 1);
    load(8'hFF, MAX_LEN + 1, 0, "bad9");
    chk("bad9_err", int'(cfg_err), 1);
    clear_cnt();
    feed_vec(16'b10110, 5, "after_bad");
    chk("after_bad_op", int'(op), 1);

    // Full-width pattern: no match can come before the 8th bit.
    load(8'hA5, 8, 1, "ldA5");
    clear_cnt();
    feed_vec(16'hA5, 8, "a5");
    chk("a5_op", int'(op), 1);
    chk("a5_total", int'(match_count), 1);

    // en gaps with junk on `in` are ignored.
    load(8'b10110, 5, 1, "ldgap");
    clear_cnt();
    begin
      logic [4:0] p;
      p = 5'b10110;
      for (int i = 4; i >= 0; i--) begin
        step(0, 0, 1'($urandom), 0, 8'h00, 0, 0, "gap_idle");
        step(0, 1, p[i], 0, 8'h00, 0, 0, "gap_bit");
      end
    end
    chk("gap_total", int'(match_count), 1);

    // Saturation on the 2-bit counter, then clear on the same edge as a match.
    load(8'b11, 2, 1, "ld11");
    clear_cnt();
    for (int i = 0; i < 7; i++) feed(1'b1, "sat");
    chk("sat_cnt2", int'(match_count2), 3);
    chk("sat_cnt", int'(match_count), 6);
    step(0, 1, 1, 1, 8'h00, 0, 0, "clr_hit");
    chk("clr_hit_op", int'(op), 1);
    chk("clr_hit_cnt", int'(match_count), 0);

    // Asynchronous reset in the middle of a partial pattern.
    load(8'b10110, 5, 1, "ldrst");
    clear_cnt();
    feed_vec(16'b1011, 4, "prerst");
    @(posedge clk);
    #3 rst = 1'b1;
    model_reset();
    #1;
    chk_all("async_rst");
    @(negedge clk);
    rst = 1'b0;
    feed(1'b0, "postrst");
    chk("postrst_op", int'(op), 0);
    chk("postrst_cnt", int'(match_count), 0);

    // Random traffic, mostly short patterns so that matches happen often.
    for (int it = 0; it < 600; it++) begin
      int r, len;
      r   = int'($urandom_range(0, 24));
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9))
                                        : int'($urandom_range(1, 3));
      step(r == 0, $urandom_range(0, 3) != 0, 1'($urandom), r == 1,
           8'($urandom), len, 1'($urandom), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
